// File: rtl/prog_mod_counter_pkg.sv
// Shared constants for the programmable modulus counter: smallest legal modulus
// and the encoding of the count-direction input.
package prog_mod_counter_pkg;
   localparam int MIN_MOD = 2;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;
endpackage

// File: rtl/prog_mod_counter_mod_shadow_reg.sv
// Pending/active modulus pair: validates writes, shadows them until a commit
// strobe (load or wrap), pulses mod_err one cycle after a rejected write.
module prog_mod_counter_mod_shadow_reg
   import prog_mod_counter_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_MOD = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mod_wr,
   input  logic [WIDTH-1:0] mod_val,
   input  logic             commit,
   output logic [WIDTH-1:0] active_mod,
   output logic [WIDTH-1:0] m_eff,
   output logic             mod_err
);
   localparam logic [WIDTH-1:0] MIN_M = WIDTH'(MIN_MOD);
   localparam logic [WIDTH-1:0] RST_M = WIDTH'(DEFAULT_MOD);

   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             mod_err_q, mod_err_d;
   logic             wr_ok;

   assign m_eff = pend_vld_q ? pend_q : active_q;
   assign wr_ok = mod_wr && (mod_val >= MIN_M);

   always_comb begin
      active_d   = active_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      mod_err_d  = mod_wr && !wr_ok;
      if (commit) begin
         active_d   = m_eff;
         pend_vld_d = 1'b0;
      end
      // A write landing on the commit edge is kept for the following commit.
      if (wr_ok) begin
         pend_d     = mod_val;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q   <= RST_M;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         mod_err_q  <= 1'b0;
      end else begin
         active_q   <= active_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         mod_err_q  <= mod_err_d;
      end
   end

   assign active_mod = active_q;
   assign mod_err    = mod_err_q;
endmodule

// File: rtl/prog_mod_counter.sv
// Up/down modulo-M counter with runtime modulus, load, wrap/saturate and tc pulse.
// All outputs registered, one-cycle latency; no backpressure (en gates counting).
module prog_mod_counter
   import prog_mod_counter_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_MOD = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_wr,
   input  logic [WIDTH-1:0] mod_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] active_mod,
   output logic             tc,
   output logic             mod_err
);
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             commit;
   logic [WIDTH-1:0] m_eff;
   logic [WIDTH-1:0] cur_top, eff_top;

   prog_mod_counter_mod_shadow_reg #(
      .WIDTH      (WIDTH),
      .DEFAULT_MOD(DEFAULT_MOD)
   ) u_mod_shadow_reg (
      .clk       (clk),
      .reset     (reset),
      .mod_wr    (mod_wr),
      .mod_val   (mod_val),
      .commit    (commit),
      .active_mod(active_mod),
      .m_eff     (m_eff),
      .mod_err   (mod_err)
   );

   // Both moduli are always >= 2, so subtracting one cannot underflow.
   assign cur_top = active_mod - 1'b1;
   assign eff_top = m_eff - 1'b1;

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      commit  = 1'b0;
      if (load) begin
         commit  = 1'b1;
         count_d = (load_val > eff_top) ? eff_top : load_val;
      end else if (en) begin
         if (dir_e'(up) == DIR_UP) begin
            if (count_q != cur_top) begin
               count_d = count_q + 1'b1;
            end else begin
               tc_d = 1'b1;
               if (!sat_mode) begin
                  commit  = 1'b1;
                  count_d = '0;
               end
            end
         end else begin
            if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               tc_d = 1'b1;
               if (!sat_mode) begin
                  commit  = 1'b1;
                  count_d = eff_top;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
endmodule
